// File: rtl/bcd_updown_counter.sv
// Purpose: parametrised multi-digit BCD up/down counter with validated parallel load, wrap/saturate terminal handling.
// Latency: q, ovf and load_err update one clock edge after the inputs; ena and tc are combinational from q and inputs.
// Backpressure: none; the counter takes en/load every cycle, and a rejected load is flagged on load_err.
module bcd_updown_counter #(
  parameter int DIGITS = 4,
  parameter bit WRAP   = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  up,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   q,
  output logic [DIGITS-2:0]     ena,
  output logic                  tc,
  output logic                  ovf,
  output logic                  load_err
);

  localparam int W = 4 * DIGITS;

  // Registered state and its next-state values
  logic [W-1:0]      q_q, q_d;
  logic              ovf_q, ovf_d;
  logic              load_err_q, load_err_d;

  // Per-digit decode of the current count
  logic [DIGITS-1:0] dig_is9;
  logic [DIGITS-1:0] dig_is0;
  logic              all9;
  logic              all0;

  // Carry/borrow chain before and after the saturate override
  logic [DIGITS-1:0] dig_en_raw;
  logic [DIGITS-1:0] dig_en;
  logic              tc_evt;
  logic              sat_hold;
  logic              load_ok;

  // One BCD digit step: 9 rolls to 0 going up, 0 rolls to 9 going down
  function automatic logic [3:0] bcd_step(input logic [3:0] d, input logic inc);
    logic [3:0] r;
    if (inc) begin
      r = (d == 4'd9) ? 4'd0 : d + 4'd1;
    end else begin
      r = (d == 4'd0) ? 4'd9 : d - 4'd1;
    end
    return r;
  endfunction

  // Decode which digits sit at 9 or 0; terminal count needs all of them
  always_comb begin
    dig_is9 = '0;
    dig_is0 = '0;
    for (int i = 0; i < DIGITS; i++) begin
      dig_is9[i] = (q_q[4*i +: 4] == 4'd9);
      dig_is0[i] = (q_q[4*i +: 4] == 4'd0);
    end
    all9 = &dig_is9;
    all0 = &dig_is0;
  end

  // Ripple enable: a digit steps only when every lower digit is at its rollover value
  always_comb begin
    dig_en_raw    = '0;
    dig_en_raw[0] = en;
    for (int i = 1; i < DIGITS; i++) begin
      dig_en_raw[i] = dig_en_raw[i-1] & (up ? dig_is9[i-1] : dig_is0[i-1]);
    end
  end

  // Terminal count and the saturate override; tc ignores load, the event does not
  always_comb begin
    tc       = en & (up ? all9 : all0);
    tc_evt   = tc & ~load;
    // In saturate mode the advisory enables drop as soon as tc is seen,
    // while the internal step enables only need to freeze on a real event.
    sat_hold = ~WRAP & tc;
    dig_en   = (~WRAP & tc_evt) ? '0 : dig_en_raw;
    ena      = sat_hold ? '0 : dig_en_raw[DIGITS-1:1];
  end

  // A load is accepted only if every nibble is a legal BCD digit
  always_comb begin
    load_ok = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (load_val[4*i +: 4] > 4'd9) begin
        load_ok = 1'b0;
      end
    end
  end

  // Next-state: load wins over counting; a rejected load leaves q untouched
  always_comb begin
    q_d        = q_q;
    ovf_d      = 1'b0;
    load_err_d = 1'b0;
    if (load) begin
      if (load_ok) begin
        q_d = load_val;
      end else begin
        load_err_d = 1'b1;
      end
    end else begin
      for (int i = 0; i < DIGITS; i++) begin
        if (dig_en[i]) begin
          q_d[4*i +: 4] = bcd_step(q_q[4*i +: 4], up);
        end
      end
      ovf_d = tc_evt;
    end
  end

  // State registers with synchronous reset overriding load and count
  always_ff @(posedge clk) begin
    if (reset) begin
      q_q        <= '0;
      ovf_q      <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      q_q        <= q_d;
      ovf_q      <= ovf_d;
      load_err_q <= load_err_d;
    end
  end

  assign q        = q_q;
  assign ovf      = ovf_q;
  assign load_err = load_err_q;

endmodule

// File: doc/bcd_updown_counter.md
Name: bcd_updown_counter

Overview:
Parametrised multi-digit BCD counter, the successor to the fixed 4-digit up-counter. It adds:
- configurable digit count
- up/down direction
- parallel load with digit validation
- wrap or saturate mode at terminal count
- a registered overflow/underflow pulse

It is used for timekeeping, event tallies and display-driving counters. It is a single clock domain leaf block.

Parameters:
DIGITS, 4, number of BCD digits (>=2); q width is 4*DIGITS.
WRAP, 1, 1 = roll over at terminal count; 0 = saturate (hold) at terminal count.

Ports:
clk  input  1  clock; all state updates on rising edge.
reset  input  1  synchronous, active-high reset.
en  input  1  count enable; one step per cycle when high.
up  input  1  direction: 1 = increment, 0 = decrement.
load  input  1  parallel load request.
load_val  input  4*DIGITS  load value, digit i in bits [4i+3:4i].
q  output  4*DIGITS  counter value, digit 0 least significant; registered.
ena  output  DIGITS-1  ena[i-1] = step enable of digit i (i=1..DIGITS-1); combinational.
tc  output  1  terminal count; combinational.
ovf  output  1  registered one-cycle pulse on wrap or saturate event.
load_err  output  1  registered one-cycle pulse on rejected load.

Behaviour:
- Reset values: q = 0 (all digits 0), ovf = 0, load_err = 0.
- Priority on each edge: reset > load > en. With en low and no load or reset, q holds.
- Load, all digits of load_val <= 9:
  - q <= load_val next edge.
  - load_err <= 0, ovf <= 0.
- Load, any digit of load_val >= 10:
  - q unchanged.
  - load_err <= 1 for exactly one cycle.
  - ovf <= 0.
- Load takes effect regardless of en and up.
- Digit step enable, up: dig_en[0] = en; dig_en[i] = en & (digits 0..i-1 all == 9).
- Digit step enable, down: dig_en[0] = en; dig_en[i] = en & (digits 0..i-1 all == 0).
- Stepping a digit:
  - Up: 9 -> 0, else +1.
  - Down: 0 -> 9, else -1.
  - Digits with dig_en = 0 hold.
- q can never contain a digit > 9; only reset, validated load and BCD stepping write it.
- tc = en & (up ? all digits == 9 : all digits == 0). tc is independent of load, but the load-over-en priority still applies.
- Terminal count event = tc high and no load or reset that cycle.
  - WRAP = 1: normal stepping applies. q rolls to all 0 (up) or all 9 (down).
  - WRAP = 0: q holds. All dig_en are forced to 0.
  - ovf <= 1 for exactly one cycle after the edge, in both modes.
- ena[i-1] = dig_en[i], with these zeroing rules:
  - WRAP = 0 and tc: ena is all 0.
  - load or reset: ena still reflects dig_en. It is an advisory, combinational output.
- ovf = 0 on any cycle without a terminal count event. Back-to-back terminal events give consecutive ovf pulses (e.g. saturate mode with en held).
- Direction change takes effect on the same edge; there is no pipeline.
- Reset mid-count clears q and both pulse outputs on the same edge, regardless of load or en.
- Latency: q reflects an input one edge later. ovf and load_err assert in the same cycle as the q update they describe.

Test Plan:
- Reset and ena/tc (DIGITS=4, WRAP=1): reset, then en=1, up=1 for 1000 cycles -> q = 16'h1000. At q=16'h0999 with en=1: ena = 3'b111, tc = 0.
- Up terminal wrap (DIGITS=4, WRAP=1): load 16'h9999, then en=1, up=1 -> tc=1, next q = 16'h0000, ovf=1 for one cycle, then ovf=0 as q -> 16'h0001.
- Down borrow and saturate (DIGITS=4, WRAP=0): load 16'h0100, en=1, up=0 -> q = 16'h0099, 16'h0098, ...
  - Reach 16'h0000 -> tc=1, ena=3'b000, q holds 16'h0000.
  - ovf stays high every cycle en remains high.
- Load validation: load_val = 16'h12A4 -> q unchanged, load_err pulses one cycle. load_val = 16'h1234 -> q = 16'h1234, load_err = 0.
- Priority and simultaneity: at q=16'h9999 with en=1, up=1, load=1, load_val=16'h0500 -> q = 16'h0500, ovf = 0. The same cycle with reset=1 -> q = 16'h0000, all pulses 0.
- Parametrisation: DIGITS=6, WRAP=1, load 24'h099999, en=1, up=1 -> q = 24'h100000. ena[4:0] all 1 before the edge.
